// File: rtl/ddr_prbs_test_ctrl.sv
// PRBS31 memory test sequencer: writes WORD_NUM generator words from BASE_ADDR,
// reads them back with bounded outstanding reads and counts mismatches.
module ddr_prbs_test_ctrl #(
   parameter int ADDR_W    = 27,
   parameter int WORD_NUM  = 1024,
   parameter int BASE_ADDR = 0,
   parameter int MAX_OUTST = 8
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              start,
   output logic              seq_rst,
   output logic              gen_en,
   input  logic              gen_vld,
   input  logic [31:0]       gen_data,
   output logic              chk_en,
   input  logic [31:0]       chk_data,
   output logic              mem_write,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_waitrequest,
   input  logic              mem_rdata_vld,
   input  logic [31:0]       mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_cnt,
   output logic [ADDR_W-1:0] first_err_addr
);

   // Counters need one extra bit so WORD_NUM = 2^ADDR_W is representable.
   localparam int CNT_W = ADDR_W + 1;
   localparam int OUT_W = $clog2(MAX_OUTST + 1);
   localparam logic [CNT_W-1:0]  WN    = CNT_W'(WORD_NUM);
   localparam logic [CNT_W-1:0]  WN_M1 = CNT_W'(WORD_NUM - 1);
   localparam logic [OUT_W-1:0]  MAXO  = OUT_W'(MAX_OUTST);
   localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WR_LOAD  = 3'd1;
   localparam logic [2:0] WR_REQ   = 3'd2;
   localparam logic [2:0] RD_PRIME = 3'd3;
   localparam logic [2:0] RD_REQ   = 3'd4;
   localparam logic [2:0] RD_DRAIN = 3'd5;
   localparam logic [2:0] DONE     = 3'd6;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              wr_q, wr_d;
   logic              seq_rst_q, seq_rst_d;
   logic [CNT_W-1:0]  issued_q, issued_d;
   logic [CNT_W-1:0]  rcv_q, rcv_d;
   logic [OUT_W-1:0]  outst_q, outst_d;
   logic [15:0]       err_q, err_d;
   logic              pass_q, pass_d;
   logic [ADDR_W-1:0] ferr_q, ferr_d;

   logic rd_ok, rd_acc, rd_vld, mism;

   assign rd_ok  = (state_q == RD_REQ) && (issued_q < WN) && (outst_q < MAXO);
   assign rd_acc = rd_ok && !mem_waitrequest;
   assign rd_vld = mem_rdata_vld && ((state_q == RD_REQ) || (state_q == RD_DRAIN));
   assign mism   = rd_vld && (mem_rdata != chk_data);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_d      = wr_q;
      seq_rst_d = 1'b0;
      issued_d  = issued_q;
      rcv_d     = rcv_q;
      outst_d   = outst_q;
      err_d     = err_q;
      pass_d    = pass_q;
      ferr_d    = ferr_q;

      if (rd_acc && !rd_vld)
         outst_d = outst_q + 1'b1;
      else if (!rd_acc && rd_vld)
         outst_d = outst_q - 1'b1;

      if (rd_acc) begin
         addr_d   = addr_q + 1'b1;
         issued_d = issued_q + 1'b1;
      end

      // Responses return in order, so the received count locates the word.
      if (rd_vld) begin
         rcv_d = rcv_q + 1'b1;
         if (mism) begin
            if (err_q != 16'hFFFF) err_d = err_q + 1'b1;
            if (err_q == 16'h0000) ferr_d = BASE + rcv_q[ADDR_W-1:0];
         end
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               seq_rst_d = 1'b1;
               err_d     = '0;
               pass_d    = 1'b0;
               ferr_d    = '0;
               addr_d    = BASE;
               issued_d  = '0;
               rcv_d     = '0;
               outst_d   = '0;
               wr_d      = 1'b0;
               state_d   = WR_LOAD;
            end
         end
         WR_LOAD: state_d = WR_REQ;
         WR_REQ: begin
            if (!wr_q) begin
               if (gen_vld) begin
                  wdata_d = gen_data;
                  wr_d    = 1'b1;
               end
            end else if (!mem_waitrequest) begin
               wr_d     = 1'b0;
               addr_d   = addr_q + 1'b1;
               issued_d = issued_q + 1'b1;
               state_d  = (issued_q == WN_M1) ? RD_PRIME : WR_LOAD;
            end
         end
         RD_PRIME: begin
            addr_d   = BASE;
            issued_d = '0;
            state_d  = RD_REQ;
         end
         RD_REQ: begin
            if (issued_q == WN) state_d = RD_DRAIN;
         end
         RD_DRAIN: begin
            // Result is made visible together with the done pulse.
            if (rcv_q == WN) begin
               pass_d  = (err_q == 16'h0000);
               state_d = DONE;
            end
         end
         DONE: begin
            pass_d  = (err_d == 16'h0000);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wr_q      <= 1'b0;
         seq_rst_q <= 1'b0;
         issued_q  <= '0;
         rcv_q     <= '0;
         outst_q   <= '0;
         err_q     <= '0;
         pass_q    <= 1'b0;
         ferr_q    <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wr_q      <= wr_d;
         seq_rst_q <= seq_rst_d;
         issued_q  <= issued_d;
         rcv_q     <= rcv_d;
         outst_q   <= outst_d;
         err_q     <= err_d;
         pass_q    <= pass_d;
         ferr_q    <= ferr_d;
      end
   end

   assign seq_rst        = seq_rst_q;
   assign gen_en         = (state_q == WR_LOAD);
   assign chk_en         = (state_q == RD_PRIME) || rd_vld;
   assign mem_write      = wr_q;
   assign mem_read       = rd_ok;
   assign mem_addr       = addr_q;
   assign mem_wdata      = wdata_q;
   assign busy           = (state_q != IDLE);
   assign done           = (state_q == DONE);
   assign pass           = pass_q;
   assign err_cnt        = err_q;
   assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_ddr_prbs_test_ctrl.sv
// Bench for ddr_prbs_test_ctrl: PRBS generator stand-ins, a stalling in-order
// memory with programmable latency/corruption, and an expected-result model.
module tb_ddr_prbs_test_ctrl;
   localparam int AW = 8, WN = 16, BASE = 246, MO = 2;
   localparam logic [30:0] SEED = 31'h1234_5678;

   logic clk_sys = 1'b0, reset = 1'b1, start = 1'b0;
   logic seq_rst, gen_en, chk_en, mem_write, mem_read, busy, done, pass;
   logic gen_vld = 1'b0, mem_waitrequest = 1'b0, mem_rdata_vld = 1'b0;
   logic [31:0] gen_data = '0, chk_data = '0, mem_rdata = '0, mem_wdata;
   logic [AW-1:0] mem_addr, first_err_addr;
   logic [15:0] err_cnt;
   logic [71:0] outs;

   ddr_prbs_test_ctrl #(.ADDR_W(AW), .WORD_NUM(WN), .BASE_ADDR(BASE), .MAX_OUTST(MO)) dut (
      .clk_sys(clk_sys), .reset(reset), .start(start), .seq_rst(seq_rst),
      .gen_en(gen_en), .gen_vld(gen_vld), .gen_data(gen_data),
      .chk_en(chk_en), .chk_data(chk_data),
      .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_waitrequest(mem_waitrequest), .mem_rdata_vld(mem_rdata_vld), .mem_rdata(mem_rdata),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_err_addr(first_err_addr));

   always #5 clk_sys = ~clk_sys;

   assign outs = {seq_rst, gen_en, chk_en, mem_write, mem_read, mem_addr, mem_wdata,
                  busy, done, pass, err_cnt, first_err_addr};

   function automatic logic [30:0] p31(input logic [30:0] s);
      for (int k = 0; k < 32; k++) s = {s[29:0], s[30] ^ s[27]};
      return s;
   endfunction
   function automatic logic [31:0] word(input logic [30:0] s);
      return {s[30] ^ s[0], s};
   endfunction

   // Generator stand-ins: reseed and advance may coincide; reseed applies first.
   logic [30:0] glfsr, clfsr, g_tmp, c_tmp;
   always @(posedge clk_sys) begin
      g_tmp = seq_rst ? SEED : glfsr;
      c_tmp = seq_rst ? SEED : clfsr;
      if (gen_en) begin gen_data <= word(g_tmp); gen_vld <= 1'b1; glfsr <= p31(g_tmp); end
      else begin gen_vld <= 1'b0; glfsr <= g_tmp; end
      if (chk_en) begin chk_data <= word(c_tmp); clfsr <= p31(c_tmp); end
      else clfsr <= c_tmp;
   end

   typedef struct { int rdy; int ep; logic [31:0] d; } rsp_t;
   rsp_t rq[$];
   logic [31:0] exp_w [WN];
   logic [31:0] corr [WN];
   logic [31:0] mem [256];
   int cyc = 0, n_wr, n_rd, outst_m = 0, max_o, epoch = 0, stray_cnt;
   int e_wr_addr, e_wr_data, e_rd_addr, e_stab, e_ovl, e_ovr, stall_seen, done_cnt, seqrst_cnt;
   int lat_fix = 0, wr_stall_at = -1, rd_stall_at = -1, stall_left = 0, lat_m;
   bit rnd_stall = 0, rnd_gap = 0;
   logic p_wr = 0, p_rd = 0, p_wait = 0, w_m;
   logic [AW-1:0] p_addr;
   logic [31:0] p_wdata;
   logic [15:0] d_err, exp_err;
   logic d_pass, exp_pass;
   logic [AW-1:0] d_first, exp_first;
   int checks = 0, errors = 0;

   // Memory model runs on the falling edge: it sees settled requests and sets
   // waitrequest/response for the coming rising edge, so acceptance is known here.
   always @(negedge clk_sys) begin
      cyc++;
      if (done) begin done_cnt++; d_err = err_cnt; d_pass = pass; d_first = first_err_addr; end
      if (seq_rst) seqrst_cnt++;
      if (p_wait && p_wr && !(mem_write && mem_addr == p_addr && mem_wdata == p_wdata)) e_stab++;
      if (p_wait && p_rd && !(mem_read && mem_addr == p_addr)) e_stab++;
      if (stall_left > 0) begin w_m = 1'b1; stall_left--; end
      else if (mem_write && n_wr == wr_stall_at) begin w_m = 1'b1; stall_left = 4; wr_stall_at = -1; end
      else if (mem_read && n_rd == rd_stall_at) begin w_m = 1'b1; stall_left = 4; rd_stall_at = -1; end
      else w_m = rnd_stall && ($urandom_range(0, 3) == 0);
      mem_waitrequest = w_m;
      if (w_m && (mem_write || mem_read)) stall_seen++;
      if (mem_write && mem_read) e_ovl++;
      if (mem_read && outst_m >= MO) e_ovr++;
      if (mem_write && !w_m) begin
         if (mem_addr != AW'(BASE + n_wr)) e_wr_addr++;
         if (n_wr >= WN || mem_wdata != exp_w[n_wr]) e_wr_data++;
         mem[mem_addr] = mem_wdata;
         n_wr++;
      end
      if (mem_read && !w_m) begin
         if (mem_addr != AW'(BASE + n_rd)) e_rd_addr++;
         lat_m = (lat_fix > 0) ? lat_fix : $urandom_range(1, 6);
         rq.push_back('{cyc + lat_m, epoch, mem[mem_addr] ^ ((n_rd < WN) ? corr[n_rd] : 32'h0)});
         n_rd++;
         outst_m++;
      end
      if (rq.size() > 0 && rq[0].rdy <= cyc && !(rnd_gap && $urandom_range(0, 2) == 0)) begin
         mem_rdata_vld = 1'b1;
         mem_rdata = rq[0].d;
         if (rq[0].ep == epoch) outst_m--; else stray_cnt++;
         void'(rq.pop_front());
      end else begin
         mem_rdata_vld = 1'b0;
         mem_rdata = $urandom;
      end
      if (outst_m > max_o) max_o = outst_m;
      p_wr = mem_write; p_rd = mem_read; p_wait = w_m; p_addr = mem_addr; p_wdata = mem_wdata;
   end

   // Expected result of a pass: one error per corrupted word, first one located by index.
   task automatic model_expect();
      bit found = 0;
      exp_err = '0; exp_first = '0;
      for (int i = 0; i < WN; i++)
         if (corr[i] != 0) begin
            if (!found) exp_first = AW'(BASE + i);
            found = 1;
            exp_err++;
         end
      exp_pass = (exp_err == 0);
   endtask

   task automatic kick();
      n_wr = 0; n_rd = 0; max_o = 0; e_wr_addr = 0; e_wr_data = 0; e_rd_addr = 0;
      e_stab = 0; e_ovl = 0; e_ovr = 0; stall_seen = 0; done_cnt = 0; seqrst_cnt = 0;
      @(posedge clk_sys); #1 start = 1'b1;
      @(posedge clk_sys); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int tmo);
      int k = 0;
      while (done_cnt == 0 && k < tmo) begin @(negedge clk_sys); #1; k++; end
      if (done_cnt == 0) begin
         checks++; errors++;
         $display("FAIL done_timeout got no done within %0d cycles", tmo);
      end
      repeat (3) @(negedge clk_sys);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk_sys);
      #1; checks++;
      if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", outs); end
      @(negedge clk_sys) reset = 1'b0;
      repeat (2) @(posedge clk_sys);
      #1; checks++;
      if (outs !== '0) begin errors++; $display("FAIL idle_outputs got %h exp 0", outs); end
   endtask

   task automatic test_basic();
      rnd_stall = 1; rnd_gap = 1; lat_fix = 0;
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < WN; i++) corr[i] = '0;
         if (it == 1) corr[2] = 32'h1;
         else if (it >= 2)
            repeat ($urandom_range(1, 3)) corr[$urandom_range(0, WN - 1)] = $urandom | 32'h1;
         model_expect();
         kick(); wait_done(3000);
         checks++; if (n_wr != WN || n_rd != WN) begin errors++;
            $display("FAIL basic_counts it%0d got wr %0d rd %0d exp %0d", it, n_wr, n_rd, WN); end
         checks++; if (e_wr_addr + e_wr_data + e_rd_addr + e_ovl + e_ovr + e_stab != 0) begin errors++;
            $display("FAIL basic_protocol it%0d got wa %0d wd %0d ra %0d ovl %0d ovr %0d stab %0d exp 0",
                     it, e_wr_addr, e_wr_data, e_rd_addr, e_ovl, e_ovr, e_stab); end
         checks++; if (done_cnt != 1) begin errors++;
            $display("FAIL basic_done_pulses it%0d got %0d exp 1", it, done_cnt); end
         checks++; if (d_err !== exp_err || d_pass !== exp_pass || d_first !== exp_first) begin errors++;
            $display("FAIL basic_result it%0d got err %0d pass %0b first %0d exp err %0d pass %0b first %0d",
                     it, d_err, d_pass, d_first, exp_err, exp_pass, exp_first); end
         checks++; if (err_cnt !== exp_err || pass !== exp_pass || first_err_addr !== exp_first || busy !== 1'b0) begin
            errors++; $display("FAIL basic_hold it%0d got err %0d pass %0b first %0d busy %0b exp %0d %0b %0d 0",
                     it, err_cnt, pass, first_err_addr, busy, exp_err, exp_pass, exp_first); end
      end
   endtask

   task automatic test_latency();
      rnd_stall = 0; rnd_gap = 0; lat_fix = 10;
      for (int i = 0; i < WN; i++) corr[i] = '0;
      kick(); wait_done(3000);
      checks++; if (e_ovr != 0 || max_o != MO) begin errors++;
         $display("FAIL lat_outstanding got over %0d max %0d exp 0 %0d", e_ovr, max_o, MO); end
      checks++; if (d_pass !== 1'b1 || d_err !== 16'h0 || n_rd != WN) begin errors++;
         $display("FAIL lat_result got pass %0b err %0d rd %0d exp 1 0 %0d", d_pass, d_err, n_rd, WN); end
   endtask

   task automatic test_waitreq();
      rnd_stall = 0; rnd_gap = 0; lat_fix = 3; wr_stall_at = 5; rd_stall_at = 7;
      kick(); wait_done(3000);
      checks++; if (e_stab != 0 || stall_seen != 10) begin errors++;
         $display("FAIL wait_stable got unstable %0d stalls %0d exp 0 10", e_stab, stall_seen); end
      checks++; if (e_wr_addr + e_rd_addr + e_wr_data != 0 || n_wr != WN || n_rd != WN) begin errors++;
         $display("FAIL wait_addr got bad %0d wr %0d rd %0d exp 0 %0d %0d",
                  e_wr_addr + e_rd_addr + e_wr_data, n_wr, n_rd, WN, WN); end
      checks++; if (d_pass !== 1'b1) begin errors++;
         $display("FAIL wait_pass got %0b exp 1", d_pass); end
   endtask

   task automatic test_back_to_back();
      rnd_stall = 1; rnd_gap = 1; lat_fix = 0;
      for (int i = 0; i < WN; i++) corr[i] = '0;
      corr[5] = 32'h10;
      model_expect();
      kick();
      repeat (10) @(posedge clk_sys);
      #1 start = 1'b1; @(posedge clk_sys); #1 start = 1'b0;
      wait_done(3000);
      for (int p = 0; p < 2; p++) begin
         if (p == 1) begin kick(); wait_done(3000); end
         checks++; if (seqrst_cnt != 1 || done_cnt != 1 || n_wr != WN) begin errors++;
            $display("FAIL b2b_pass%0d got seq_rst %0d done %0d wr %0d exp 1 1 %0d",
                     p, seqrst_cnt, done_cnt, n_wr, WN); end
         checks++; if (d_err !== exp_err || d_pass !== exp_pass || d_first !== exp_first || e_wr_data != 0) begin
            errors++; $display("FAIL b2b_result%0d got err %0d pass %0b first %0d wd %0d exp %0d %0b %0d 0",
                     p, d_err, d_pass, d_first, e_wr_data, exp_err, exp_pass, exp_first); end
      end
   endtask

   task automatic test_reset_mid();
      int k = 0;
      rnd_stall = 0; rnd_gap = 0; lat_fix = 10; stray_cnt = 0;
      for (int i = 0; i < WN; i++) corr[i] = 32'hFFFF_FFFF;
      kick();
      while (n_rd < 2 && k < 500) begin @(negedge clk_sys); #1; k++; end
      reset = 1'b1; epoch++; outst_m = 0; p_wait = 1'b0;
      #1; checks++;
      if (outs !== '0) begin errors++; $display("FAIL rst_mid_outputs got %h exp 0 (reads %0d)", outs, n_rd); end
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;
      repeat (25) @(negedge clk_sys);
      #1; checks++;
      if (err_cnt !== 16'h0 || done_cnt != 0 || busy !== 1'b0 || stray_cnt == 0) begin errors++;
         $display("FAIL rst_mid_stray got err %0d done %0d busy %0b strays %0d exp 0 0 0 >0",
                  err_cnt, done_cnt, busy, stray_cnt); end
      for (int i = 0; i < WN; i++) corr[i] = '0;
      kick(); wait_done(3000);
      checks++; if (d_pass !== 1'b1 || d_err !== 16'h0 || n_rd != WN || done_cnt != 1) begin errors++;
         $display("FAIL rst_mid_next got pass %0b err %0d rd %0d done %0d exp 1 0 %0d 1",
                  d_pass, d_err, n_rd, done_cnt, WN); end
   endtask

   initial begin
      logic [30:0] s;
      s = SEED;
      for (int i = 0; i < WN; i++) begin exp_w[i] = word(s); s = p31(s); corr[i] = '0; end
      test_reset();
      test_basic();
      test_latency();
      test_waitreq();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
